uart_tx_bridge: RTL and testbench
=================================

UART_TX_BRIDGE -- requirements
Module: uart_tx_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, default configure::clks_per_bit (216), is the bit period minus one, in clock cycles.
REQ-002 Parameter DEPTH, default configure::fetchbuffer_depth (4), is the TX FIFO entry count; it SHALL be a power of two, at least 2.
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 uart_valid  in  1  request strobe from the bus decoder (address in uart_base_addr..uart_top_addr).
REQ-006 uart_addr  in  32  byte address; only bits [1:0] are examined.
REQ-007 uart_wdata  in  32  write data; only bits [7:0] are used.
REQ-008 uart_wstrb  in  4  byte strobes; nonzero means write, zero means read.
REQ-009 uart_rdata  out  32  read data, valid while uart_ready=1.
REQ-010 uart_ready  out  1  one-cycle completion pulse.
REQ-011 uart_tx  out  1  serial line, idle high.

Function
REQ-012 A write SHALL enqueue uart_wdata[7:0] only when uart_wstrb[0]=1 and the FIFO is not full.
REQ-013 On a write with uart_wstrb[0]=1 and the FIFO not full, the enqueue and uart_ready=1 SHALL occur in the cycle after uart_valid.
REQ-014 A write with uart_wstrb[0]=1 while the FIFO is full SHALL stall: uart_ready stays 0 until an entry frees, then the enqueue and ready occur next cycle.
REQ-015 Writes with uart_wstrb[0]=0 and wstrb nonzero SHALL complete next cycle with no enqueue.
REQ-016 A read SHALL complete next cycle with uart_rdata = {29'b0, fifo_empty, fifo_full, tx_busy}.
REQ-017 tx_busy in the status word SHALL mean the FSM is not IDLE.
REQ-018 uart_ready SHALL be high for exactly one cycle per request.
REQ-019 uart_valid is held by the master until uart_ready; a new request is never presented in the same cycle as uart_ready.
REQ-020 The FIFO SHALL use pointers one bit wider than log2(DEPTH).
REQ-021 FIFO full SHALL be: pointers' MSBs differ and the remaining bits are equal; empty SHALL be: pointers equal. Pointer wrap-around SHALL be natural modulo 2*DEPTH.
REQ-022 A simultaneous enqueue and dequeue SHALL be permitted, including when the FIFO is full; occupancy is then unchanged.
REQ-023 The TX FSM SHALL have states IDLE, START, DATA and STOP.
REQ-024 IDLE: uart_tx=1; when the FIFO is not empty, dequeue the head into the shift register, clear the baud and bit counters, and go to START.
REQ-025 START: uart_tx=0 for CLKS_PER_BIT+1 cycles, then go to DATA.
REQ-026 DATA: send 8 bits LSB first, each held CLKS_PER_BIT+1 cycles; after bit 7, go to STOP.
REQ-027 STOP: uart_tx=1 for CLKS_PER_BIT+1 cycles, then go to IDLE.
REQ-028 Back-to-back frames SHALL have exactly one IDLE cycle between the stop bit and the next start bit.
REQ-029 The baud counter SHALL count 0..CLKS_PER_BIT and wrap to 0; the bit counter is 3 bits.
REQ-030 uart_tx SHALL be driven from a register, so the line is glitch-free.

Reset
REQ-031 Reset asserted SHALL immediately force: FSM=IDLE, uart_tx=1, uart_ready=0, uart_rdata=0, all pointers and counters 0, and a pending stalled write discarded.
REQ-032 Reset mid-frame SHALL abort the frame; the line returns high at once, and FIFO contents are lost.
REQ-033 The FIFO storage array is not reset.

Structure
REQ-034 CLKS_PER_BIT and DEPTH defaults come from package configure; the FSM state enum SHALL be declared in configure.
REQ-035 The FIFO SHALL be a separate sub-module uart_fifo (DEPTH, 8-bit data, push/pop/full/empty); the FSM, baud counter and bus logic stay in uart_tx_bridge.

Verification
REQ-036 Scenario 1: with CLKS_PER_BIT=216, write 0x55 -> ready the next cycle; the line shows start=0, then 1,0,1,0,1,0,1,0, then stop=1, each 217 cycles, for a 2170-cycle frame.
REQ-037 Scenario 2: 5 back-to-back writes with DEPTH=4 while the first byte transmits -> the 5th write stalls until the first dequeue; all 5 bytes are emitted in order with one IDLE cycle between frames.
REQ-038 Scenario 3: read status when idle -> rdata=0x4; while transmitting with the FIFO full -> rdata=0x3.
REQ-039 Scenario 4: assert reset during DATA bit 3 -> uart_tx=1 asynchronously, status reads 0x4 after release, and no residual frame is sent.
REQ-040 Scenario 5: write with wstrb=4'b0010 -> ready the next cycle with no enqueue and the line stays high.
REQ-041 Scenario 6: enqueue and dequeue in the same cycle with the FIFO full -> full stays 1, and the byte order is preserved across pointer wrap.

Source files
------------

// File: rtl/uart_tx_bridge_pkg.sv
// configure: shared defaults and the TX state encoding for the UART bridge
package configure;
  localparam int clks_per_bit = 216;
  localparam int fetchbuffer_depth = 4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_bridge_fifo.sv
// uart_fifo: byte FIFO with extra-MSB pointers; push on full is legal only alongside pop
module uart_fifo
  import configure::*;
#(
  parameter int DEPTH = fetchbuffer_depth
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [7:0] mem [DEPTH];
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clock)
    if (push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_bridge.sv
// uart_tx_bridge: bus-facing write FIFO feeding an 8N1 UART transmitter with status readback
module uart_tx_bridge
  import configure::*;
#(
  parameter int CLKS_PER_BIT = clks_per_bit,
  parameter int DEPTH = fetchbuffer_depth
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_tx
);
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  tx_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n, dout;
  logic pop, push, full, empty, tx_n, bit_end, accept, wr, wr0, done;
  logic unused_bits;
  assign unused_bits = ^{uart_addr, uart_wdata[31:8]};
  uart_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .din(uart_wdata[7:0]), .dout(dout), .full(full), .empty(empty)
  );
  // the ready cycle still sees uart_valid high, so it must not be re-accepted
  assign accept = uart_valid && !uart_ready;
  assign wr = |uart_wstrb;
  assign wr0 = wr && uart_wstrb[0];
  assign push = accept && wr0 && (!full || pop);
  assign done = accept && (!wr0 || !full || pop);
  assign bit_end = baud == BW'(CLKS_PER_BIT);
  always_comb begin
    state_n = state;
    baud_n = baud + 1'b1;
    bit_n = bit_cnt;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_n = dout;
          state_n = START;
        end
      end
      START: if (bit_end) begin
        baud_n = '0;
        state_n = DATA;
      end
      DATA: if (bit_end) begin
        baud_n = '0;
        bit_n = bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) state_n = STOP;
      end
      default: if (bit_end) begin
        baud_n = '0;
        state_n = IDLE;
      end
    endcase
    // line level is registered from the next state so uart_tx never glitches
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[bit_n] : 1'b1;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      uart_tx <= 1'b1;
      uart_ready <= 1'b0;
      uart_rdata <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      uart_tx <= tx_n;
      uart_ready <= done;
      uart_rdata <= (accept && !wr) ? {29'b0, empty, full, state != IDLE} : '0;
    end
endmodule

// File: tb/tb_uart_tx_bridge.sv
// tb_uart_tx_bridge: directed checks of bus handshake, status word and serial framing
module tb_uart_tx_bridge;
  localparam int CPB = 216;
  localparam int BIT = CPB + 1;
  logic clock = 0, reset = 1, uart_valid = 0;
  logic [31:0] uart_addr = 0, uart_wdata = 0, uart_rdata;
  logic [3:0] uart_wstrb = 0;
  logic uart_ready, uart_tx;
  int n_assert = 0, n_fail = 0;
  int lat, w, lows;
  logic [31:0] rd;
  logic [7:0] exp_b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  uart_tx_bridge #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .uart_valid(uart_valid), .uart_addr(uart_addr),
    .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata),
    .uart_ready(uart_ready), .uart_tx(uart_tx)
  );
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [3:0] strb, input logic [7:0] data, output int l, output logic [31:0] r);
    @(negedge clock);
    uart_valid = 1;
    uart_addr = 32'h1000_0000;
    uart_wdata = {24'hABCDEF, data};
    uart_wstrb = strb;
    l = 0;
    do begin
      @(negedge clock);
      l++;
    end while (uart_ready !== 1'b1 && l < 6000);
    r = uart_rdata;
    if (uart_ready !== 1'b1) chk("ready_timeout", 0, 1);
    uart_valid = 0;
    uart_wstrb = 0;
    @(negedge clock);
    chk("ready_pulse", uart_ready, 0);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (uart_tx !== 1'b0 && n < 6000);
    if (uart_tx !== 1'b0) chk("start_timeout", 0, 1);
  endtask

  // called on the first start-bit cycle; checks first and last cycle of every bit
  task automatic recv(input logic [7:0] eb, input string tag);
    int b;
    logic e;
    for (int off = 0; off < 10 * BIT; off++) begin
      if (off > 0) @(negedge clock);
      if (off % BIT == 0 || off % BIT == CPB) begin
        b = off / BIT;
        e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
        chk($sformatf("%s_bit%0d", tag, b), uart_tx, e);
      end
    end
  endtask

  task automatic line_idle(input int n, output int lo);
    lo = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) lo++;
    end
  endtask

  initial begin
    #2 reset = 0;
    #1;
    chk("rst_tx", uart_tx, 1);
    chk("rst_ready", uart_ready, 0);
    chk("rst_rdata", uart_rdata, 0);
    repeat (3) @(negedge clock);
    reset = 1;
    bus(4'b0000, 8'h00, lat, rd);
    chk("idle_status_lat", lat, 1);
    chk("idle_status", rd, 32'h4);
    fork
      begin
        bus(4'b0001, 8'h55, lat, rd);
        chk("s1_lat", lat, 1);
      end
      begin
        wait_start(w);
        recv(8'h55, "s1");
      end
    join
    fork
      begin
        bus(4'b0001, exp_b[0], lat, rd);
        chk("s2_lat0", lat, 1);
        for (int i = 1; i < 5; i++) begin
          bus(4'b0001, exp_b[i], lat, rd);
          chk($sformatf("s2_lat%0d", i), lat, 1);
        end
        bus(4'b0000, 8'h00, lat, rd);
        chk("s3_full_status", rd, 32'h3);
        bus(4'b0001, exp_b[5], lat, rd);
        chk("s2_stall", lat > 100, 1);
        bus(4'b0000, 8'h00, lat, rd);
        chk("s6_full_after_swap", rd, 32'h3);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          wait_start(w);
          if (i > 0) chk($sformatf("s2_gap%0d", i), w, 2);
          recv(exp_b[i], $sformatf("s2_f%0d", i));
        end
      end
    join
    bus(4'b0000, 8'h00, lat, rd);
    chk("s2_end_status", rd, 32'h4);
    bus(4'b0001, 8'hA5, lat, rd);
    chk("s4_start", uart_tx, 0);
    bus(4'b0001, 8'h5A, lat, rd);
    repeat (4 * BIT + 47) @(negedge clock);
    chk("s4_bit3", uart_tx, 0);
    #3 reset = 0;
    #1;
    chk("s4_rst_tx", uart_tx, 1);
    chk("s4_rst_ready", uart_ready, 0);
    @(negedge clock);
    reset = 1;
    bus(4'b0000, 8'h00, lat, rd);
    chk("s4_status", rd, 32'h4);
    line_idle(3000, lows);
    chk("s4_no_residual", lows, 0);
    bus(4'b0010, 8'h77, lat, rd);
    chk("s5_lat", lat, 1);
    line_idle(500, lows);
    chk("s5_line_high", lows, 0);
    bus(4'b0000, 8'h00, lat, rd);
    chk("s5_status", rd, 32'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
